// File: rtl/lcd_sequencer.sv
// lcd_sequencer
// Master controller for the 4-bit HD44780 LCD path. After reset it runs the
// power-on init: the first four single nibbles are driven straight onto the
// LCD pins (o_init_sel=1). The remaining init byte commands go through the
// external nibble sender. Afterwards it accepts characters from a client and
// inserts the DDRAM address commands needed to wrap the cursor across lines.
//
// Ports
//   i_clk_sys        system clock (50 MHz)
//   i_reset          synchronous, active-high reset
//   i_char_valid     client offers a character on i_char
//   i_char[7:0]      ASCII character
//   i_clear          request display clear + cursor home
//   o_char_ready     high in IDLE while i_clear=0; char taken on valid&ready
//   o_init_done      sticky high once init has completed
//   o_sender_start   one-cycle start pulse to the nibble sender
//   o_sender_data    byte for the sender, held from start until done
//   i_sender_done    sender completion pulse (only honoured in CMD_WAIT)
//   o_rs             LCD RS for the current transfer (0 cmd, 1 char)
//   o_rw             LCD RW, always 0
//   o_init_sel       1: LCD pins from o_init_nibble/o_init_en, 0: from sender
//   o_init_nibble    direct nibble during init
//   o_init_en        direct EN during init
//
// state       | meaning
// ------------+------------------------------------------------------------
// PWR_WAIT    | power-on delay before the first init nibble
// NIB_SETUP   | direct nibble driven, EN low (setup)
// NIB_HIGH    | direct nibble driven, EN high
// NIB_HOLD    | direct nibble driven, EN low (hold)
// INIT_WAIT   | post-nibble delay (long after the first, short otherwise)
// CMD_START   | start pulse to the sender, data/RS already valid
// CMD_WAIT    | waiting for the sender done pulse
// CLR_WAIT    | extra settle time after a clear command
// IDLE        | init complete, ready for a character or clear request

module lcd_sequencer #(
    parameter int unsigned P_PWR_WAIT   = 750000,
    parameter int unsigned P_WAIT_LONG  = 205000,
    parameter int unsigned P_WAIT_SHORT = 5000,
    parameter int unsigned P_WAIT_CLEAR = 82000,
    parameter int unsigned P_SETUP      = 2,
    parameter int unsigned P_EN_HIGH    = 12
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic       i_char_valid,
    input  logic [7:0] i_char,
    input  logic       i_clear,
    output logic       o_char_ready,
    output logic       o_init_done,
    output logic       o_sender_start,
    output logic [7:0] o_sender_data,
    input  logic       i_sender_done,
    output logic       o_rs,
    output logic       o_rw,
    output logic       o_init_sel,
    output logic [3:0] o_init_nibble,
    output logic       o_init_en
);

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_NIB_SETUP,
        S_NIB_HIGH,
        S_NIB_HOLD,
        S_INIT_WAIT,
        S_CMD_START,
        S_CMD_WAIT,
        S_CLR_WAIT,
        S_IDLE
    } state_t;

    // What the current sender transfer belongs to; decides where CMD_WAIT goes.
    typedef enum logic [1:0] {
        CTX_INIT,
        CTX_CLEAR,
        CTX_CHAR,
        CTX_WRAP
    } ctx_t;

    localparam logic [7:0] C_CMD_CLEAR = 8'h01;
    localparam logic [7:0] C_CMD_LINE2 = 8'hC0;
    localparam logic [7:0] C_CMD_LINE1 = 8'h80;

    state_t      r_state;
    state_t      w_state_nxt;
    ctx_t        r_ctx;
    ctx_t        w_ctx_nxt;
    logic [31:0] r_wait;
    logic [31:0] w_wait_nxt;
    logic [1:0]  r_step;
    logic [1:0]  w_step_nxt;
    logic [7:0]  r_data;
    logic [7:0]  w_data_nxt;
    logic        r_rs;
    logic        w_rs_nxt;
    logic [4:0]  r_cursor;
    logic [4:0]  w_cursor_nxt;
    logic        r_init_done;
    logic        w_init_done_nxt;

    logic [31:0] w_wait_lim;
    logic        w_wait_tc;
    logic [4:0]  w_cursor_inc;
    logic        w_nib_phase;

    // Init byte commands: function set, entry mode, display on, clear.
    function automatic logic [7:0] f_init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    f_init_cmd = 8'h28;
            2'd1:    f_init_cmd = 8'h06;
            2'd2:    f_init_cmd = 8'h0C;
            default: f_init_cmd = C_CMD_CLEAR;
        endcase
    endfunction

    // Length in cycles of the current timed state. The counter counts up
    // from 0 so that the cleared reset value is the first cycle of PWR_WAIT.
    always_comb begin
        w_wait_lim = 32'd1;
        case (r_state)
            S_PWR_WAIT:  w_wait_lim = 32'(P_PWR_WAIT);
            S_NIB_SETUP: w_wait_lim = 32'(P_SETUP + 1);
            S_NIB_HIGH:  w_wait_lim = 32'(P_EN_HIGH + 1);
            S_NIB_HOLD:  w_wait_lim = 32'(P_SETUP + 1);
            S_INIT_WAIT: w_wait_lim = (r_step == 2'd0) ? 32'(P_WAIT_LONG)
                                                       : 32'(P_WAIT_SHORT);
            S_CLR_WAIT:  w_wait_lim = 32'(P_WAIT_CLEAR);
            default:     w_wait_lim = 32'd1;
        endcase
    end

    assign w_wait_tc    = (r_wait == (w_wait_lim - 32'd1));
    assign w_cursor_inc = r_cursor + 5'd1;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state     <= S_PWR_WAIT;
            r_ctx       <= CTX_INIT;
            r_wait      <= 32'd0;
            r_step      <= 2'd0;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_cursor    <= 5'd0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ctx       <= w_ctx_nxt;
            r_wait      <= w_wait_nxt;
            r_step      <= w_step_nxt;
            r_data      <= w_data_nxt;
            r_rs        <= w_rs_nxt;
            r_cursor    <= w_cursor_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ctx_nxt       = r_ctx;
        w_wait_nxt      = 32'd0;
        w_step_nxt      = r_step;
        w_data_nxt      = r_data;
        w_rs_nxt        = r_rs;
        w_cursor_nxt    = r_cursor;
        w_init_done_nxt = r_init_done;

        case (r_state)
            S_PWR_WAIT: begin
                if (w_wait_tc) w_state_nxt = S_NIB_SETUP;
                else           w_wait_nxt  = r_wait + 32'd1;
            end
            S_NIB_SETUP: begin
                if (w_wait_tc) w_state_nxt = S_NIB_HIGH;
                else           w_wait_nxt  = r_wait + 32'd1;
            end
            S_NIB_HIGH: begin
                if (w_wait_tc) w_state_nxt = S_NIB_HOLD;
                else           w_wait_nxt  = r_wait + 32'd1;
            end
            S_NIB_HOLD: begin
                if (w_wait_tc) w_state_nxt = S_INIT_WAIT;
                else           w_wait_nxt  = r_wait + 32'd1;
            end
            S_INIT_WAIT: begin
                if (w_wait_tc) begin
                    if (r_step == 2'd3) begin
                        // Direct nibbles finished; hand the pins to the sender.
                        w_step_nxt  = 2'd0;
                        w_data_nxt  = f_init_cmd(2'd0);
                        w_rs_nxt    = 1'b0;
                        w_ctx_nxt   = CTX_INIT;
                        w_state_nxt = S_CMD_START;
                    end else begin
                        w_step_nxt  = r_step + 2'd1;
                        w_state_nxt = S_NIB_SETUP;
                    end
                end else begin
                    w_wait_nxt = r_wait + 32'd1;
                end
            end
            S_CMD_START: begin
                w_state_nxt = S_CMD_WAIT;
            end
            S_CMD_WAIT: begin
                if (i_sender_done) begin
                    case (r_ctx)
                        CTX_INIT: begin
                            if (r_step == 2'd3) begin
                                w_state_nxt = S_CLR_WAIT;
                            end else begin
                                w_step_nxt  = r_step + 2'd1;
                                w_data_nxt  = f_init_cmd(r_step + 2'd1);
                                w_rs_nxt    = 1'b0;
                                w_state_nxt = S_CMD_START;
                            end
                        end
                        CTX_CLEAR: begin
                            w_state_nxt = S_CLR_WAIT;
                        end
                        CTX_CHAR: begin
                            w_cursor_nxt = w_cursor_inc;
                            if (w_cursor_inc == 5'd16) begin
                                w_data_nxt  = C_CMD_LINE2;
                                w_rs_nxt    = 1'b0;
                                w_ctx_nxt   = CTX_WRAP;
                                w_state_nxt = S_CMD_START;
                            end else if (w_cursor_inc == 5'd0) begin
                                w_data_nxt  = C_CMD_LINE1;
                                w_rs_nxt    = 1'b0;
                                w_ctx_nxt   = CTX_WRAP;
                                w_state_nxt = S_CMD_START;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end
            end
            S_CLR_WAIT: begin
                if (w_wait_tc) begin
                    w_cursor_nxt    = 5'd0;
                    w_init_done_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_wait_nxt = r_wait + 32'd1;
                end
            end
            S_IDLE: begin
                // Clear wins over a simultaneous character; that char is not taken.
                if (i_clear) begin
                    w_data_nxt  = C_CMD_CLEAR;
                    w_rs_nxt    = 1'b0;
                    w_ctx_nxt   = CTX_CLEAR;
                    w_state_nxt = S_CMD_START;
                end else if (i_char_valid) begin
                    w_data_nxt  = i_char;
                    w_rs_nxt    = 1'b1;
                    w_ctx_nxt   = CTX_CHAR;
                    w_state_nxt = S_CMD_START;
                end
            end
            default: begin
                w_state_nxt = S_PWR_WAIT;
            end
        endcase
    end

    assign w_nib_phase = (r_state == S_NIB_SETUP) || (r_state == S_NIB_HIGH) ||
                         (r_state == S_NIB_HOLD);

    assign o_char_ready   = (r_state == S_IDLE) && !i_clear;
    assign o_init_done    = r_init_done;
    assign o_sender_start = (r_state == S_CMD_START);
    assign o_sender_data  = r_data;
    assign o_rs           = r_rs;
    assign o_rw           = 1'b0;
    assign o_init_sel     = (r_state == S_PWR_WAIT) || w_nib_phase ||
                            (r_state == S_INIT_WAIT);
    assign o_init_en      = (r_state == S_NIB_HIGH);
    assign o_init_nibble  = w_nib_phase ? ((r_step == 2'd3) ? 4'h2 : 4'h3) : 4'h0;

endmodule
